// File: rtl/lfu_pkg.sv
// Shared types and helpers for the LFU replacement front end.
package lfu_pkg;

  localparam int unsigned NUM_WAYS = 4;

  typedef logic [1:0]          way_idx_t;
  typedef logic [NUM_WAYS-1:0] way_mask_t;

  function automatic way_mask_t idx2onehot(way_idx_t idx);
    way_mask_t mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/lfu_request_gen_if.sv
// Request handshake between lfu_request_gen (master) and the LFU block (slave).
interface lfu_request_gen_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  import lfu_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic            req_valid;
  logic            req_ready;
  way_mask_t       req_onehot;
  way_idx_t        req_idx;
  logic [CntW-1:0] pending_count;
  logic            drop;

  modport master (
    output req_valid, req_onehot, req_idx, pending_count, drop,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_onehot, req_idx, pending_count, drop,
    output req_ready
  );

endinterface

// File: rtl/lfu_btn_debounce.sv
// One button: 2-FF synchroniser, counter debounce and registered press event.
// LFU_AUTOREPEAT_EN adds a periodic repeat event while the button stays down.
module lfu_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 8
`ifdef LFU_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 16
`endif
) (
  input  logic timedClock,
  input  logic rst,
  input  logic btn_raw_i,
  output logic event_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            event_q, event_d;

`ifdef LFU_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cnt_inc = cnt_q + 1'b1;
    if (sync2_q != state_q) begin
      if (cnt_inc == CntW'(DEB_CYCLES)) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    // Event is registered on the same edge the debounced level rises.
    event_d = state_d & ~state_q;
`ifdef LFU_AUTOREPEAT_EN
    rep_d = '0;
    if (state_q) begin
      if (rep_q == RepW'(REPEAT_CYCLES - 1)) begin
        event_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge timedClock) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      event_q <= 1'b0;
`ifdef LFU_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
`ifdef LFU_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/lfu_request_gen.sv
// Turns raw push-buttons into an ordered, one-per-press request stream for the LFU block.
// Optional LFU_AUTOREPEAT_EN: held buttons re-issue a request every REPEAT_CYCLES cycles.
module lfu_request_gen
  import lfu_pkg::*;
#(
  parameter int unsigned NUM_BTN    = NUM_WAYS,
  parameter int unsigned DEB_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef LFU_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 16
`endif
) (
  input  logic               timedClock,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  lfu_request_gen_if.master  req_if
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [NUM_BTN-1:0] btn_event;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic               drop_q, drop_d;
  way_mask_t          push_mask;
  way_idx_t           push_idx;
  logic               push_req, push, pop, full, valid;

  way_idx_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  way_idx_t           head;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    lfu_btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES)
`ifdef LFU_AUTOREPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_deb (
      .timedClock (timedClock),
      .rst        (rst),
      .btn_raw_i  (btn_raw_i[g]),
      .event_o    (btn_event[g])
    );
  end

  // Lowest index wins, matching the consumer's b1 > b4 priority.
  always_comb begin
    push_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) push_idx = way_idx_t'(i);
    end
  end

  assign valid    = (count_q != '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign pop      = valid & req_if.req_ready;
  assign push_req = |pend_q;
  assign push     = push_req & (~full | pop);

  // An event on a bit being enqueued this edge re-arms it rather than dropping.
  always_comb begin
    push_mask = push ? idx2onehot(push_idx) : '0;
    pend_d    = btn_event | (pend_q & ~push_mask);
    drop_d    = |(btn_event & pend_q & ~push_mask);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge timedClock) begin
    if (rst) begin
      pend_q   <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge timedClock) begin
    if (push) mem_q[wr_ptr_q] <= push_idx;
  end

  assign head = mem_q[rd_ptr_q];

  assign req_if.req_valid     = valid;
  assign req_if.req_idx       = valid ? head : '0;
  assign req_if.req_onehot    = valid ? idx2onehot(head) : '0;
  assign req_if.pending_count = count_q;
  assign req_if.drop          = drop_q;

endmodule

// File: tb/tb_lfu_request_gen.sv
// Self-checking bench for lfu_request_gen: directed scenarios plus random presses,
// compared every cycle against a behavioural model of presses, pending bits and a queue.
module tb_lfu_request_gen;
  import lfu_pkg::*;

  localparam int DEB   = 8;
  localparam int DEPTH = 4;

  logic       timedClock = 1'b0;
  logic       rst        = 1'b1;
  logic [3:0] btn        = 4'b0000;

  lfu_request_gen_if #(.FIFO_DEPTH(DEPTH)) req_if ();

  lfu_request_gen #(
    .NUM_BTN    (4),
    .DEB_CYCLES (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .timedClock (timedClock),
    .rst        (rst),
    .btn_raw_i  (btn),
    .req_if     (req_if.master)
  );

  always #5 timedClock = ~timedClock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: raw level seen two edges late, a press counts once the new level
  // has been seen for DEB consecutive edges; presses wait in a pending set, then a queue.
  int m_s1[4], m_s2[4], m_lvl[4], m_run[4], m_ev[4], m_pend[4];
  int m_q[$];
  int m_drop;

  task automatic model_edge();
    int  pidx;
    bit  do_pop;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_ev[i] = 0; m_pend[i] = 0;
      end
      m_q.delete();
      m_drop = 0;
      return;
    end
    do_pop = (m_q.size() != 0) && req_if.req_ready;
    pidx = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i] != 0 && pidx < 0) pidx = i;
    if (pidx >= 0 && !(m_q.size() < DEPTH || do_pop)) pidx = -1;
    m_drop = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_ev[i] != 0) begin
        if (m_pend[i] != 0 && pidx != i) m_drop = 1;
        m_pend[i] = 1;
      end else if (pidx == i) begin
        m_pend[i] = 0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (pidx >= 0) m_q.push_back(pidx);
    for (int i = 0; i < 4; i++) begin
      m_ev[i] = 0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
          m_ev[i]  = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(btn[i]);
    end
  endtask

  int saw_valid = 0;
  int drop_cycles = 0;

  task automatic compare_outputs();
    int exp_valid, exp_idx, exp_oh;
    exp_valid = (m_q.size() != 0) ? 1 : 0;
    exp_idx   = exp_valid ? m_q[0] : 0;
    exp_oh    = exp_valid ? (1 << exp_idx) : 0;
    check_eq("req_valid", 32'(req_if.req_valid), 32'(exp_valid));
    check_eq("req_onehot", 32'(req_if.req_onehot), 32'(exp_oh));
    check_eq("req_idx", 32'(req_if.req_idx), 32'(exp_idx));
    check_eq("pending_count", 32'(req_if.pending_count), 32'(m_q.size()));
    check_eq("drop", 32'(req_if.drop), 32'(m_drop));
    if (req_if.req_valid === 1'b1) saw_valid++;
    if (req_if.drop === 1'b1) drop_cycles++;
  endtask

  task automatic step();
    @(posedge timedClock);
    model_edge();
    @(negedge timedClock);
    compare_outputs();
  endtask

  task automatic hold(int n);
    repeat (n) step();
  endtask

  initial begin
    int first;
    int first_idx;
    req_if.req_ready = 1'b1;

    // 1: reset then idle
    hold(2);
    rst = 1'b0;
    hold(3);
    check_eq("reset_valid", 32'(req_if.req_valid), 32'd0);
    check_eq("reset_count", 32'(req_if.pending_count), 32'd0);

    // 2: single press latency, valid only after edge DEB+3
    btn = 4'b0001;
    for (int e = 0; e <= 13; e++) begin
      step();
      check_eq("latency_valid", 32'(req_if.req_valid), (e == DEB + 3) ? 32'd1 : 32'd0);
      if (e == DEB + 3) begin
        check_eq("latency_onehot", 32'(req_if.req_onehot), 32'h1);
        check_eq("latency_idx", 32'(req_if.req_idx), 32'd0);
      end
    end
    btn = 4'b0000;
    hold(14);

    // 3: short glitch on b3 produces nothing
    saw_valid = 0; drop_cycles = 0;
    btn = 4'b0100;
    hold(5);
    btn = 4'b0000;
    hold(20);
    check_eq("glitch_valid_cycles", 32'(saw_valid), 32'd0);
    check_eq("glitch_drop_cycles", 32'(drop_cycles), 32'd0);

    // 4: all four at once, ready low, then drain in priority order
    req_if.req_ready = 1'b0;
    btn = 4'b1111;
    hold(16);
    check_eq("all4_count", 32'(req_if.pending_count), 32'd4);
    btn = 4'b0000;
    hold(12);
    req_if.req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_onehot", 32'(req_if.req_onehot), 32'(1 << k));
      step();
    end
    check_eq("drain_empty", 32'(req_if.req_valid), 32'd0);

    // 5: full queue, b2 pressed twice -> second press dropped
    req_if.req_ready = 1'b0;
    btn = 4'b1111;
    hold(16);
    btn = 4'b0000;
    hold(12);
    drop_cycles = 0;
    btn = 4'b0010;
    hold(12);
    btn = 4'b0000;
    hold(12);
    btn = 4'b0010;
    hold(12);
    check_eq("full_drop_cycles", 32'(drop_cycles), 32'd1);
    check_eq("full_count", 32'(req_if.pending_count), 32'd4);
    btn = 4'b0000;
    hold(12);
    req_if.req_ready = 1'b1;
    hold(10);

    // 6: b4 held through a one-edge reset reads as a fresh press
    btn = 4'b1000;
    hold(20);
    req_if.req_ready = 1'b0;
    hold(14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_count", 32'(req_if.pending_count), 32'd0);
    req_if.req_ready = 1'b1;
    first = -1;
    first_idx = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (req_if.req_valid === 1'b1 && first < 0) begin
        first     = k;
        first_idx = int'(req_if.req_idx);
      end
    end
    check_eq("rst_hold_latency", 32'(first), 32'(DEB + 4));
    check_eq("rst_hold_idx", 32'(first_idx), 32'd3);
    btn = 4'b0000;
    hold(14);

    // Random phase: sparse presses, random ready, rare resets
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      btn = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) begin
        req_if.req_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 499) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
